// File: rtl/register_control_fsm.sv
// Command sequencer for the X/Y/Z register file and ALU: turns one accepted
// opcode into a fixed per-cycle pattern of register instruction codes.
module register_control_fsm #(
    parameter int SHAMT_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         opcode,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [2:0]         tx,
    output logic [2:0]         ty,
    output logic [2:0]         tz,
    output logic [1:0]         tula,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOADX,
        S_COMPUTE,
        S_COMMIT,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [2:0] I_HOLD   = 3'b000;
    localparam logic [2:0] I_LOAD   = 3'b001;
    localparam logic [2:0] I_SHIFTR = 3'b010;
    localparam logic [2:0] I_SHIFTL = 3'b011;
    localparam logic [2:0] I_RESET  = 3'b100;

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_LDX = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [2:0]         tx_q, tx_d;
    logic [2:0]         ty_q, ty_d;
    logic [2:0]         tz_q, tz_d;
    logic [1:0]         tula_q, tula_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // ADD..OR map onto ALU selects 00..11; every other command presents 00.
    function automatic logic [1:0] alu_sel(input logic [2:0] op);
        logic [2:0] diff;
        diff = op - 3'd2;
        if (op >= 3'd2 && op <= 3'd5) begin
            return diff[1:0];
        end
        return 2'b00;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = opcode;
                    cnt_d = shamt;
                    case (opcode)
                        OP_CLR:         state_d = S_CLEAR;
                        OP_LDX:         state_d = S_LOADX;
                        OP_SHR, OP_SHL: state_d = (shamt == '0) ? S_DONE : S_SHIFT;
                        default:        state_d = S_COMPUTE;
                    endcase
                end
            end
            S_CLEAR, S_LOADX, S_COMMIT: state_d = S_DONE;
            S_COMPUTE:                  state_d = S_COMMIT;
            S_SHIFT: begin
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        tx_d   = I_HOLD;
        ty_d   = I_HOLD;
        tz_d   = I_HOLD;
        tula_d = alu_sel(op_d);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        case (state_d)
            S_IDLE:    tula_d = 2'b00;
            S_CLEAR: begin
                tx_d = I_RESET;
                ty_d = I_RESET;
                tz_d = I_RESET;
            end
            S_LOADX:   tx_d = I_LOAD;
            S_COMPUTE: ty_d = I_LOAD;
            S_COMMIT:  tz_d = I_LOAD;
            S_SHIFT:   tz_d = op_d[0] ? I_SHIFTL : I_SHIFTR;
            default:   ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'b000;
            tx_q    <= I_HOLD;
            ty_q    <= I_HOLD;
            tz_q    <= I_HOLD;
            tula_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tz_q    <= tz_d;
            tula_q  <= tula_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign ty   = ty_q;
    assign tz   = tz_q;
    assign tula = tula_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
